// File: rtl/aes128_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_core
//
// Iterative AES-128 forward cipher. One block per operation, one round per
// clock, with the key schedule expanded on the fly alongside the data path.
// The round-10 key is exported so the decryption side can walk its inverse
// key schedule backwards without re-expanding the cipher key.
//
// Ports
//   Clk            : single clock, all state updates on the rising edge
//   Reset_n        : asynchronous active-low reset
//   start          : request, sampled only while ready=1
//   plaintext      : input block, captured on the accepting edge
//   key            : cipher key, captured on the accepting edge
//   ready          : idle, a start is accepted this cycle
//   done           : one-cycle pulse when ciphertext is updated
//   ciphertext     : result register, holds until the next completion
//   round_key_last : round-10 key, updated together with ciphertext
//
// Byte order is FIPS-197: [127:120] is s(0,0), [119:112] is s(1,0), and the
// columns are 32-bit words with w0 = [127:96].
// ---------------------------------------------------------------------------
module aes128_encrypt_core (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] ciphertext,
  output logic [127:0] round_key_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // FIPS-197 forward S-box, row-major by high nibble.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // -------------------------------------------------------------------------
  // Round primitives
  // -------------------------------------------------------------------------

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  // Byte index of s(r,c) is r + 4c, stored at bits [127-8*(r+4c) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  // One column times the circulant [02 03 01 01]; 03*a is xtime(a)^a.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // Round constant for round r (1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   round;

  // -------------------------------------------------------------------------
  // Combinational round: key schedule step and data path step in parallel
  // -------------------------------------------------------------------------
  logic [31:0]  key_t;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_rk;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;

  // SubWord(RotWord(w3)); RotWord moves the top byte to the bottom.
  assign key_t   = sub_word({rk[23:0], rk[31:24]}) ^ {rcon(round), 24'h0};
  assign nw0     = rk[127:96] ^ key_t;
  assign nw1     = rk[95:64]  ^ nw0;
  assign nw2     = rk[63:32]  ^ nw1;
  assign nw3     = rk[31:0]   ^ nw2;
  assign next_rk = {nw0, nw1, nw2, nw3};

  assign shifted   = shift_rows(sub_bytes(state));
  assign mixed     = mix_columns(shifted);
  // The final round skips MixColumns.
  assign round_out = ((round == 4'd10) ? shifted : mixed) ^ next_rk;

  // -------------------------------------------------------------------------
  // Control and state update
  // -------------------------------------------------------------------------
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, which is what makes rk/state/round step
  // together as one round.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm            <= IDLE;
      ready          <= 1'b1;
      done           <= 1'b0;
      ciphertext     <= '0;
      round_key_last <= '0;
      state          <= '0;
      rk             <= '0;
      round          <= '0;
    end else begin
      // done is a single-cycle pulse: cleared every edge unless round 10 sets it.
      done <= 1'b0;
      if (fsm == IDLE) begin
        if (start) begin
          state <= plaintext ^ key;
          rk    <= key;
          round <= 4'd1;
          ready <= 1'b0;
          fsm   <= RUN;
        end
      end else begin
        state <= round_out;
        rk    <= next_rk;
        if (round == 4'd10) begin
          ciphertext     <= round_out;
          round_key_last <= next_rk;
          done           <= 1'b1;
          ready          <= 1'b1;
          fsm            <= IDLE;
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes128_encrypt_core
//
// Self-checking bench. A transaction-level AES-128 model (S-box derived from
// the GF(2^8) inverse plus affine map, full key expansion into 44 words)
// predicts each result at the accepting edge; a cycle model tracks busy,
// done and the output registers, and a compare process checks every cycle.
// Directed tests add literal FIPS-197 expectations, latency, back-to-back,
// ignored start, input hold and mid-run reset.
// ---------------------------------------------------------------------------
module tb_aes128_encrypt_core;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         ready;
  logic         done;
  logic [127:0] ciphertext;
  logic [127:0] round_key_last;

  aes128_encrypt_core dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .start          (start),
    .plaintext      (plaintext),
    .key            (key),
    .ready          (ready),
    .done           (done),
    .ciphertext     (ciphertext),
    .round_key_last (round_key_last)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_vec = 0;
  int n_err = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference AES-128
  // -------------------------------------------------------------------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] o;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = o;
    end
  endtask

  function automatic void aes_model(input logic [127:0] pt, input logic [127:0] k,
                                    output logic [127:0] ct, output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++)
            s[row+4*c] = gmul(8'h02, t[row+4*c]) ^ gmul(8'h03, t[(row+1)%4+4*c])
                       ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    rk10 = {w[40], w[41], w[42], w[43]};
  endfunction

  // -------------------------------------------------------------------------
  // Cycle model: busy for ten edges after acceptance, then publish
  // -------------------------------------------------------------------------
  logic         m_busy = 1'b0;
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_ct   = '0;
  logic [127:0] m_rkl  = '0;
  logic [127:0] p_ct, p_rk;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      m_ct   = '0;
      m_rkl  = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_ct   = p_ct;
          m_rkl  = p_rk;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = 10;
        aes_model(plaintext, key, p_ct, p_rk);
      end
    end
  end

  always @(negedge Clk) begin
    check("cyc_ready", {127'd0, ready}, {127'd0, !m_busy});
    check("cyc_done", {127'd0, done}, {127'd0, m_done});
    check("cyc_ct", ciphertext, m_ct);
    check("cyc_rkl", round_key_last, m_rkl);
  end

  // Sampled at posedge, before the DUT's edge updates land.
  always @(posedge Clk) if (done) n_pulses++;

  // -------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // -------------------------------------------------------------------------
  task automatic launch(input logic [127:0] p, input logic [127:0] k);
    check("ready_at_start", {127'd0, ready}, 128'd1);
    start     = 1'b1;
    plaintext = p;
    key       = k;
    @(negedge Clk);
    start     = 1'b0;
    plaintext = '1;
    key       = '1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!done && n < 40);
    check("done_seen", {127'd0, done}, 128'd1);
  endtask

  int lat;
  int pulses0;
  logic [127:0] mct, mrk;

  initial begin
    Reset_n   = 1'b0;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    build_sbox();

    // Pin the reference model to the published vectors.
    check("sbox_00", {120'd0, sb[0]}, 128'h63);
    check("sbox_53", {120'd0, sb[8'h53]}, 128'hed);
    aes_model(PT_B, KEY_B, mct, mrk);
    check("model_ct_b", mct, CT_B);
    check("model_rk_b", mrk, RK_B);
    aes_model(PT_C, KEY_C, mct, mrk);
    check("model_ct_c", mct, CT_C);
    check("model_rk_c", mrk, RK_C);

    // Reset state.
    repeat (2) @(negedge Clk);
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    check("rst_rkl", round_key_last, 128'd0);
    Reset_n = 1'b1;

    // App. B vector; launch drives all-ones onto the inputs right after acceptance.
    launch(PT_B, KEY_B);
    wait_done(lat);
    check("lat_b", 128'(lat), 128'd10);
    check("ct_b", ciphertext, CT_B);
    check("rkl_b", round_key_last, RK_B);
    @(negedge Clk);

    // C.1 vector.
    launch(PT_C, KEY_C);
    wait_done(lat);
    check("lat_c", 128'(lat), 128'd10);
    check("ct_c", ciphertext, CT_C);
    check("rkl_c", round_key_last, RK_C);
    @(negedge Clk);

    // Back-to-back: C.1 starts in B's done cycle; B result must hold until then.
    launch(PT_B, KEY_B);
    wait_done(lat);
    check("b2b_ct_b", ciphertext, CT_B);
    launch(PT_C, KEY_C);
    lat = 1;
    do begin
      @(negedge Clk);
      lat++;
      if (!done) check("b2b_hold", ciphertext, CT_B);
    end while (!done && lat < 40);
    check("b2b_gap", 128'(lat), 128'd11);
    check("b2b_ct_c", ciphertext, CT_C);
    check("b2b_rkl_c", round_key_last, RK_C);
    @(negedge Clk);

    // start pulsed with other data during RUN cycles 3..5 is ignored.
    launch(PT_B, KEY_B);
    repeat (2) @(negedge Clk);
    start = 1'b1; plaintext = PT_C; key = KEY_C;
    repeat (3) @(negedge Clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 128'(lat + 5), 128'd10);
    check("ign_ct", ciphertext, CT_B);
    pulses0 = n_pulses;
    repeat (15) @(negedge Clk);
    check("ign_pulses", 128'(n_pulses - pulses0), 128'd1);

    // Reset during round 6 aborts; a following C.1 run completes.
    launch(PT_B, KEY_B);
    repeat (5) @(negedge Clk);
    pulses0 = n_pulses;
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("abort_ready", {127'd0, ready}, 128'd1);
    check("abort_done", {127'd0, done}, 128'd0);
    check("abort_ct", ciphertext, 128'd0);
    check("abort_rkl", round_key_last, 128'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) @(negedge Clk);
    check("abort_no_done", 128'(n_pulses - pulses0), 128'd0);
    launch(PT_C, KEY_C);
    wait_done(lat);
    check("post_rst_lat", 128'(lat), 128'd10);
    check("post_rst_ct", ciphertext, CT_C);
    check("post_rst_rkl", round_key_last, RK_C);
    repeat (2) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_core.md
# aes128_encrypt_core

Iterative AES-128 forward cipher: encrypts one 128-bit block per operation, one round per clock, with on-the-fly key expansion. It is the encrypt-side counterpart to the existing decryption datapath (InvShiftRows/InvSubBytes/InvAddRoundKey/InvMixColumns). It also exports the final (round-10) round key, so the decryption side can run its inverse key schedule backwards without re-expanding.

## Interface

Parameters: none. The block is fixed at AES-128, Nk=4, Nr=10.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready=1.
- plaintext  input  128  input block, captured on the accepting edge.
- key  input  128  cipher key, captured on the accepting edge.
- ready  output  1  idle; a start is accepted this cycle.
- done  output  1  one-cycle pulse when ciphertext is updated.
- ciphertext  output  128  result register; holds until the next completion.
- round_key_last  output  128  round-10 key; updated together with ciphertext.

## Operation

- Byte order follows FIPS-197 throughout. Bits [127:120] are byte 0 = s(0,0), [119:112] = s(1,0), and so on. Columns are 32-bit words, w0 = [127:96].
- Internal registers:
  - state[127:0]
  - rk[127:0], the current round key
  - round[3:0]
  - FSM with states IDLE and RUN.
- IDLE: ready=1.
  - If start=1, then state <= plaintext ^ key, rk <= key, round <= 1, and the FSM moves to RUN.
- RUN: ready=0. Each edge performs round r = round.
  - Next key: t = SubWord(RotWord(rk.w3)) ^ {Rcon[r], 24'h0}.
    - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
    - rk <= new key.
  - Rounds 1–9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ new key.
  - Round 10: MixColumns is omitted.
    - ciphertext <= result and round_key_last <= new key.
    - done <= 1; the FSM returns to IDLE.
  - Otherwise round <= round + 1.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- MixColumns operates in GF(2^8) with xtime reduction polynomial 0x11B. Matrix rows are [02 03 01 01] and its rotations.
- S-box is the FIPS-197 table. Twenty combinational lookups: 16 for state, 4 for the key schedule.
- start while ready=0 is ignored; there is no queueing.
- plaintext and key may change freely after the accepting edge.

## Timing

- Reset values (asserted asynchronously):
  - FSM=IDLE, ready=1, done=0
  - ciphertext=0, round_key_last=0
  - state=0, rk=0, round=0
- Latency: start is sampled high at edge E0. Rounds 1..10 execute on E1..E10.
  - done=1 and the new ciphertext are visible in the cycle after E10, i.e. 10 cycles after the accept cycle.
  - ready returns to 1 in that same cycle.
- done is high for exactly one cycle per operation. It is registered and never combinational from start.
- Back-to-back: start=1 in the cycle done=1 is accepted. Throughput is one block per 11 cycles.
- ciphertext and round_key_last stay stable through the next operation until its own E10.
- Reset_n low mid-operation aborts the operation:
  - All registers return to reset values immediately.
  - No done pulse is produced and ciphertext reads 0.
- Reset_n deassertion is synchronised externally. The first edge with Reset_n=1 may accept a start.

## Test plan

- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734.
  - Expect ct=3925841d02dc09fbdc118597196a0b32 and round_key_last=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done must rise exactly 10 cycles after the accept cycle.
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff.
  - Expect ct=69c4e0d86a7b0430d8cdb78070b4c55a and round_key_last=13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: issue vector B, then start=1 for vector C.1 in the done cycle.
  - Both results are correct; the second done comes 11 cycles after the first.
  - The B ciphertext holds until the second done.
- Ignored start: pulse start with different data during RUN cycles 3–5.
  - Result is still B's ct; no extra done pulse.
- Reset mid-run: assert Reset_n=0 at round 6.
  - Immediately ready=1, done=0, ciphertext=0.
  - A following C.1 run completes correctly.
- Input hold: change plaintext/key to all-ones on the cycle after acceptance.
  - Result is unaffected; the B vector ct is still correct.
